// File: rtl/contador_ascendente.sv
// Up-counter from 0 to a limit latched at start, with pause and a one-cycle done pulse.
// Optional macro CONTADOR_AUTORELOAD_EN: wrap to 0 at the limit and keep counting until reset.
//
// state | meaning
// IDLE  | waiting for start; count holds its last value
// COUNT | counting up towards lim_q; busy high
// DONE  | one-cycle done pulse, then back to IDLE
module contador_ascendente #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pause,
  input  logic [N-1:0] limit_number,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] lim_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      lim_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lim_q <= limit_number;
            count <= '0;
            busy  <= 1'b1;
            state <= COUNT;
          end
        end
        COUNT: begin
          done <= 1'b0;
          if (!pause) begin
            if (count == lim_q) begin
`ifdef CONTADOR_AUTORELOAD_EN
              count <= '0;
              done  <= 1'b1;
`else
              // count stays at lim_q through DONE and IDLE
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`endif
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_ascendente.sv
// Self-checking bench for contador_ascendente: cycle model comparison plus directed scenarios.
module tb_contador_ascendente;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic [N-1:0] limit_number = '0;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  contador_ascendente #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pause        (pause),
    .limit_number (limit_number),
    .count        (count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference: a run is "active" while busy; the done pulse marks the single
  // cycle between the end of a run and the return to idle.
  int m_cnt = 0;
  int m_lim = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_lim  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      if (!pause) begin
        if (m_cnt == m_lim) begin
          m_done <= 1'b1;
`ifdef CONTADOR_AUTORELOAD_EN
          m_cnt  <= 0;
`else
          m_busy <= 1'b0;
`endif
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (start) begin
      m_lim  <= int'(limit_number);
      m_cnt  <= 0;
      m_busy <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int v);
    int k;
    for (k = 0; k < 400; k++) begin
      if (busy === 1'b1 && int'(count) == v) break;
      tick();
    end
    if (k == 400) check("wait_count_timeout", int'(count), v);
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 400; k++) begin
      if (done === 1'b1) break;
      tick();
    end
    if (k == 400) check("wait_done_timeout", int'(done), 1);
  endtask

  task automatic launch(input int lim);
    limit_number = N'(lim);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic compare_loop();
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model_count", int'(count), m_cnt);
      check("model_busy", int'(busy), int'(m_busy));
      check("model_done", int'(done), int'(m_done));
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_pulses++;
    end
  endtask

  task automatic stimulus();
    int b0;
    int d0;
    tick();
    tick();
    check("reset_count", int'(count), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    tick();

`ifdef CONTADOR_AUTORELOAD_EN
    b0 = busy_cycles; d0 = done_pulses;
    launch(2);
    repeat (11) tick();
    tick();
    check("reload_busy_cycles", busy_cycles - b0, 12);
    check("reload_done_pulses", done_pulses - d0, 3);
    check("reload_still_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reload_rst_busy", int'(busy), 0);
    check("reload_rst_count", int'(count), 0);
    tick();
`else
    // basic run to 6
    b0 = busy_cycles; d0 = done_pulses;
    launch(6);
    check("basic_first_count", int'(count), 0);
    wait_done();
    check("basic_done_busy", int'(busy), 0);
    tick();
    check("basic_final_count", int'(count), 6);
    check("basic_busy_cycles", busy_cycles - b0, 7);
    check("basic_done_pulses", done_pulses - d0, 1);
    tick();

    // pause for three edges while count is 3
    b0 = busy_cycles; d0 = done_pulses;
    launch(6);
    wait_count(3);
    pause = 1'b1;
    repeat (3) tick();
    check("pause_hold", int'(count), 3);
    pause = 1'b0;
    wait_done();
    tick();
    check("pause_busy_cycles", busy_cycles - b0, 10);
    check("pause_done_pulses", done_pulses - d0, 1);

    // limit 0
    b0 = busy_cycles; d0 = done_pulses;
    launch(0);
    wait_done();
    tick();
    check("lim0_busy_cycles", busy_cycles - b0, 1);
    check("lim0_done_pulses", done_pulses - d0, 1);
    check("lim0_count", int'(count), 0);

    // full-scale limit, no wrap
    b0 = busy_cycles; d0 = done_pulses;
    launch(255);
    wait_done();
    check("lim255_count_at_done", int'(count), 255);
    tick();
    check("lim255_busy_cycles", busy_cycles - b0, 256);
    check("lim255_done_pulses", done_pulses - d0, 1);

    // limit change and start ignored mid-run
    b0 = busy_cycles; d0 = done_pulses;
    launch(6);
    wait_count(1);
    limit_number = N'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    check("latch_end_count", int'(count), 6);
    tick();
    check("latch_busy_cycles", busy_cycles - b0, 7);
    check("latch_done_pulses", done_pulses - d0, 1);
    check("latch_no_restart", int'(busy), 0);

    // reset mid-run, restart on the next cycle
    d0 = done_pulses;
    launch(6);
    wait_count(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_count", int'(count), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_no_pulse", done_pulses - d0, 0);
    launch(6);
    check("restart_count", int'(count), 0);
    check("restart_busy", int'(busy), 1);
    wait_done();
    tick();
    check("restart_final_count", int'(count), 6);

    // start held through DONE is taken on the first IDLE cycle
    limit_number = N'(1);
    start = 1'b1;
    tick();
    wait_done();
    tick();
    check("held_idle_busy", int'(busy), 0);
    check("held_idle_done", int'(done), 0);
    tick();
    start = 1'b0;
    check("held_restart_busy", int'(busy), 1);
    check("held_restart_count", int'(count), 0);
    wait_done();
    tick();
    tick();
`endif
  endtask

  initial begin
    fork
      stimulus();
      compare_loop();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
